ex_issue_ctrl: RTL and testbench

Issue and redirect controller for the execute stage of the pipelined core. It owns the ID→EX pipeline register's valid and control fields and accepts instructions from decode over a valid/ready handshake. It inserts load-use bubbles, holds EX on downstream backpressure, and turns the execute unit's branch/jump resolution into a registered one-cycle PC redirect plus front-end flush. It also keeps retire, redirect and stall performance counters.

---
 rtl/ex_issue_ctrl_pkg.sv | 21 ++
 rtl/ex_issue_ctrl_perf_counter.sv | 25 ++
 rtl/ex_issue_ctrl.sv | 120 ++++++++++++
 tb/tb_ex_issue_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_issue_ctrl_pkg.sv
// rtl/ex_issue_ctrl_pkg.sv - shared state encoding and EX control record for the issue controller
package ex_issue_ctrl_pkg;

    typedef enum logic {
        EXC_RUN      = 1'b0,
        EXC_REDIRECT = 1'b1
    } exc_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        is_load;
        logic        is_branch;
        logic        is_jal;
        logic        is_jalr;
        logic        valid;
    } ex_ctrl_t;

    localparam ex_ctrl_t EX_BUBBLE = '0;

endpackage

// File: rtl/ex_issue_ctrl_perf_counter.sv
// rtl/ex_issue_ctrl_perf_counter.sv - wrapping performance counter with increment enable
module perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_issue_ctrl.sv
// rtl/ex_issue_ctrl.sv - ID->EX issue control: load-use bubbles, backpressure hold, registered redirect
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid_i,
    output logic             id_ready_o,
    input  logic [31:0]      id_pc_i,
    input  logic [4:0]       id_rd_i,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic             id_is_load_i,
    input  logic             id_is_branch_i,
    input  logic             id_is_jal_i,
    input  logic             id_is_jalr_i,
    output logic             ex_valid_o,
    output logic [31:0]      ex_pc_o,
    output logic [4:0]       ex_rd_o,
    output logic             ex_is_load_o,
    output logic             ex_is_branch_o,
    output logic             ex_is_jal_o,
    output logic             ex_is_jalr_o,
    input  logic             ex_br_taken_i,
    input  logic [31:0]      ex_redirect_target_i,
    input  logic             wb_ready_i,
    output logic             retire_valid_o,
    output logic             redirect_valid_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [CNT_W-1:0] redirect_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    exc_state_e  state_q, state_d;
    ex_ctrl_t    ex_q, ex_d, id_ctrl;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic        adv, take, lu, id_ready;

    assign id_ctrl = '{pc: id_pc_i, rd: id_rd_i, is_load: id_is_load_i,
                       is_branch: id_is_branch_i, is_jal: id_is_jal_i,
                       is_jalr: id_is_jalr_i, valid: id_valid_i};

    assign adv  = ~ex_q.valid | wb_ready_i;
    assign take = ex_q.valid & wb_ready_i &
                  (ex_q.is_jal | ex_q.is_jalr | (ex_q.is_branch & ex_br_taken_i));
    assign lu   = ex_q.valid & ex_q.is_load & (ex_q.rd != 5'd0) &
                  ((id_uses_rs1_i & (id_rs1_i == ex_q.rd)) |
                   (id_uses_rs2_i & (id_rs2_i == ex_q.rd)));

    always_comb begin
        state_d    = state_q;
        ex_d       = ex_q;
        redir_pc_d = redir_pc_q;
        id_ready   = 1'b0;
        case (state_q)
            EXC_RUN: begin
                // A take squashes whatever decode offers in the same cycle.
                if (take) begin
                    redir_pc_d = ex_redirect_target_i;
                    state_d    = EXC_REDIRECT;
                    id_ready   = 1'b1;
                    ex_d       = EX_BUBBLE;
                end else if (adv && lu) begin
                    ex_d = EX_BUBBLE;
                end else if (adv) begin
                    id_ready = 1'b1;
                    ex_d     = id_ctrl;
                end
            end
            EXC_REDIRECT: begin
                id_ready = 1'b1;
                ex_d     = EX_BUBBLE;
                state_d  = EXC_RUN;
            end
            default: state_d = EXC_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EXC_RUN;
            ex_q       <= EX_BUBBLE;
            redir_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            ex_q       <= ex_d;
            redir_pc_q <= redir_pc_d;
        end
    end

    assign id_ready_o       = id_ready & ~reset;
    assign ex_valid_o       = ex_q.valid;
    assign ex_pc_o          = ex_q.pc;
    assign ex_rd_o          = ex_q.rd;
    assign ex_is_load_o     = ex_q.is_load & ex_q.valid;
    assign ex_is_branch_o   = ex_q.is_branch & ex_q.valid;
    assign ex_is_jal_o      = ex_q.is_jal & ex_q.valid;
    assign ex_is_jalr_o     = ex_q.is_jalr & ex_q.valid;
    assign retire_valid_o   = ex_q.valid & wb_ready_i;
    assign redirect_valid_o = (state_q == EXC_REDIRECT);
    assign flush_o          = redirect_valid_o;
    assign redirect_pc_o    = redir_pc_q;

    perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
        .clk(clk), .reset(reset), .inc_i(retire_valid_o), .cnt_o(retired_cnt_o)
    );
    perf_counter #(.CNT_W(CNT_W)) u_redirect_cnt (
        .clk(clk), .reset(reset), .inc_i(take), .cnt_o(redirect_cnt_o)
    );
    perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc_i(id_valid_i & ~id_ready_o), .cnt_o(stall_cnt_o)
    );

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// tb/tb_ex_issue_ctrl.sv - self-checking bench for ex_issue_ctrl with retire-order scoreboard
module tb_ex_issue_ctrl;

    localparam int CW = 4;
    localparam logic [3:0] ALU = 4'h0, LD = 4'h8, BR = 4'h4, JAL = 4'h2, JALR = 4'h1;

    logic          clk, reset;
    logic          id_valid_i, id_ready_o;
    logic [31:0]   id_pc_i;
    logic [4:0]    id_rd_i, id_rs1_i, id_rs2_i;
    logic          id_uses_rs1_i, id_uses_rs2_i;
    logic          id_is_load_i, id_is_branch_i, id_is_jal_i, id_is_jalr_i;
    logic          ex_valid_o;
    logic [31:0]   ex_pc_o;
    logic [4:0]    ex_rd_o;
    logic          ex_is_load_o, ex_is_branch_o, ex_is_jal_o, ex_is_jalr_o;
    logic          ex_br_taken_i;
    logic [31:0]   ex_redirect_target_i;
    logic          wb_ready_i, retire_valid_o, redirect_valid_o, flush_o;
    logic [31:0]   redirect_pc_o;
    logic [CW-1:0] retired_cnt_o, redirect_cnt_o, stall_cnt_o;

    int tot = 0;
    int bad = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    ex_issue_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .id_valid_i(id_valid_i), .id_ready_o(id_ready_o), .id_pc_i(id_pc_i),
        .id_rd_i(id_rd_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_uses_rs1_i(id_uses_rs1_i), .id_uses_rs2_i(id_uses_rs2_i),
        .id_is_load_i(id_is_load_i), .id_is_branch_i(id_is_branch_i),
        .id_is_jal_i(id_is_jal_i), .id_is_jalr_i(id_is_jalr_i),
        .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_rd_o(ex_rd_o),
        .ex_is_load_o(ex_is_load_o), .ex_is_branch_o(ex_is_branch_o),
        .ex_is_jal_o(ex_is_jal_o), .ex_is_jalr_o(ex_is_jalr_o),
        .ex_br_taken_i(ex_br_taken_i), .ex_redirect_target_i(ex_redirect_target_i),
        .wb_ready_i(wb_ready_i), .retire_valid_o(retire_valid_o),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .flush_o(flush_o), .retired_cnt_o(retired_cnt_o),
        .redirect_cnt_o(redirect_cnt_o), .stall_cnt_o(stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic [3:0] cls);
        id_valid_i     = v;
        id_pc_i        = pc;
        id_rd_i        = rd;
        id_rs1_i       = rs1;
        id_rs2_i       = rs2;
        id_uses_rs1_i  = u1;
        id_uses_rs2_i  = u2;
        id_is_load_i   = cls[3];
        id_is_branch_i = cls[2];
        id_is_jal_i    = cls[1];
        id_is_jalr_i   = cls[0];
    endtask

    task automatic do_reset();
        reset = 1'b1;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        wb_ready_i = 1'b1;
        ex_br_taken_i = 1'b0;
        ex_redirect_target_i = 32'h0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Scoreboard: every retirement must match the next expected PC in order.
    always @(negedge clk) begin
        if (!reset && retire_valid_o) begin
            tot++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL retire_unexpected: got pc 0x%0h expected no retire", ex_pc_o);
            end else begin
                sb_exp = exp_q.pop_front();
                if (ex_pc_o !== sb_exp) begin
                    bad++;
                    $display("FAIL retire_pc: got 0x%0h expected 0x%0h", ex_pc_o, sb_exp);
                end
            end
        end
    end

    typedef struct {
        logic [4:0] ld_rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       exp_stall;
    } lu_vec_t;

    lu_vec_t lu_tab[6];

    initial begin
        int exp_stall;
        logic [31:0] pcl, pca;

        lu_tab[0] = '{5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1};
        lu_tab[1] = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0};
        lu_tab[2] = '{5'd7, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1};
        lu_tab[3] = '{5'd7, 5'd0, 5'd7, 1'b1, 1'b0, 1'b0};
        lu_tab[4] = '{5'd9, 5'd3, 5'd4, 1'b1, 1'b1, 1'b0};
        lu_tab[5] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b1, 1'b1};

        // Reset state, with decode offering an instruction throughout.
        do_reset();
        reset = 1'b1;
        id_valid_i = 1'b1;
        #1 chk("ready_in_reset", 32'(id_ready_o), 32'd0);
        tick();
        reset = 1'b0;
        id_valid_i = 1'b0;
        chk("rst_ex_valid", 32'(ex_valid_o), 32'd0);
        chk("rst_redirect", 32'(redirect_valid_o), 32'd0);
        chk("rst_flush", 32'(flush_o), 32'd0);
        chk("rst_redirect_pc", redirect_pc_o, 32'd0);
        chk("rst_cnts", 32'({retired_cnt_o, redirect_cnt_o, stall_cnt_o}), 32'd0);

        // Straight line of ALU ops.
        for (int i = 0; i < 5; i++) begin
            set_id(1'b1, 32'h100 + 32'(4 * i), 5'(i + 1), 5'd0, 5'd0, 1'b0, 1'b0, ALU);
            #1 chk("sl_ready", 32'(id_ready_o), 32'd1);
            exp_q.push_back(32'h100 + 32'(4 * i));
            tick();
            chk("sl_ex_pc", ex_pc_o, 32'h100 + 32'(4 * i));
            chk("sl_ex_valid", 32'(ex_valid_o), 32'd1);
        end
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        tick();
        chk("sl_retired", 32'(retired_cnt_o), 32'd5);
        chk("sl_no_redirect", 32'({redirect_valid_o, redirect_cnt_o}), 32'd0);

        // Load-use vectors.
        do_reset();
        exp_stall = 0;
        for (int i = 0; i < 6; i++) begin
            pcl = 32'h1000 + 32'(i * 16);
            pca = pcl + 32'd4;
            set_id(1'b1, pcl, lu_tab[i].ld_rd, 5'd0, 5'd0, 1'b0, 1'b0, LD);
            exp_q.push_back(pcl);
            tick();
            chk("lu_ld_flag", 32'(ex_is_load_o), 32'd1);
            set_id(1'b1, pca, 5'd1, lu_tab[i].rs1, lu_tab[i].rs2, lu_tab[i].u1, lu_tab[i].u2, ALU);
            #1 chk("lu_ready", 32'(id_ready_o), 32'(!lu_tab[i].exp_stall));
            exp_q.push_back(pca);
            tick();
            if (lu_tab[i].exp_stall) begin
                exp_stall++;
                chk("lu_bubble", 32'(ex_valid_o), 32'd0);
                chk("lu_stall_cnt", 32'(stall_cnt_o), 32'(exp_stall));
                tick();
            end
            chk("lu_add_pc", ex_pc_o, pca);
            chk("lu_add_valid", 32'(ex_valid_o), 32'd1);
            set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
            tick();
            chk("lu_stall_total", 32'(stall_cnt_o), 32'(exp_stall));
        end
        chk("lu_retired", 32'(retired_cnt_o), 32'd12);

        // Taken branch: wrong-path instructions must never retire.
        do_reset();
        set_id(1'b1, 32'h200, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, BR);
        exp_q.push_back(32'h200);
        tick();
        ex_br_taken_i = 1'b1;
        ex_redirect_target_i = 32'h180;
        set_id(1'b1, 32'h204, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        #1 chk("br_ready_take", 32'(id_ready_o), 32'd1);
        chk("br_no_early_pulse", 32'(redirect_valid_o), 32'd0);
        tick();
        ex_br_taken_i = 1'b0;
        chk("br_pulse", 32'(redirect_valid_o), 32'd1);
        chk("br_flush", 32'(flush_o), 32'd1);
        chk("br_target", redirect_pc_o, 32'h180);
        chk("br_ex_empty", 32'(ex_valid_o), 32'd0);
        set_id(1'b1, 32'h208, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        #1 chk("br_ready_redirect", 32'(id_ready_o), 32'd1);
        tick();
        chk("br_pulse_gone", 32'(redirect_valid_o), 32'd0);
        chk("br_discarded", 32'(ex_valid_o), 32'd0);
        chk("br_redirect_cnt", 32'(redirect_cnt_o), 32'd1);
        set_id(1'b1, 32'h180, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        exp_q.push_back(32'h180);
        tick();
        chk("br_correct_path", ex_pc_o, 32'h180);
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        tick();
        chk("br_retired", 32'(retired_cnt_o), 32'd2);

        // JALR held by backpressure.
        do_reset();
        set_id(1'b1, 32'h300, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, JALR);
        exp_q.push_back(32'h300);
        tick();
        wb_ready_i = 1'b0;
        ex_redirect_target_i = 32'h3a0;
        set_id(1'b1, 32'h304, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        for (int i = 0; i < 3; i++) begin
            #1 chk("jr_ready_held", 32'(id_ready_o), 32'd0);
            chk("jr_no_retire", 32'(retire_valid_o), 32'd0);
            tick();
            chk("jr_no_pulse", 32'(redirect_valid_o), 32'd0);
            chk("jr_hold_pc", ex_pc_o, 32'h300);
            chk("jr_hold_flag", 32'(ex_is_jalr_o), 32'd1);
        end
        wb_ready_i = 1'b1;
        #1 chk("jr_ready_release", 32'(id_ready_o), 32'd1);
        tick();
        chk("jr_pulse", 32'(redirect_valid_o), 32'd1);
        chk("jr_target", redirect_pc_o, 32'h3a0);
        chk("jr_stall_cnt", 32'(stall_cnt_o), 32'd3);
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        tick();
        chk("jr_pulse_once", 32'(redirect_valid_o), 32'd0);
        chk("jr_redirect_cnt", 32'(redirect_cnt_o), 32'd1);

        // Reset landing on the REDIRECT cycle.
        do_reset();
        set_id(1'b1, 32'h400, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, JAL);
        exp_q.push_back(32'h400);
        tick();
        ex_redirect_target_i = 32'h480;
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        tick();
        chk("rr_pulse", 32'(redirect_valid_o), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rr_pulse_killed", 32'(redirect_valid_o), 32'd0);
        chk("rr_pc_cleared", redirect_pc_o, 32'd0);
        chk("rr_cnts", 32'({retired_cnt_o, redirect_cnt_o, stall_cnt_o}), 32'd0);
        chk("rr_ex_valid", 32'(ex_valid_o), 32'd0);
        tick();
        chk("rr_no_late_pulse", 32'(redirect_valid_o), 32'd0);

        // Counter wrap at 4 bits.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_id(1'b1, 32'h800 + 32'(4 * i), 5'd1, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
            exp_q.push_back(32'h800 + 32'(4 * i));
            tick();
        end
        set_id(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, ALU);
        tick();
        chk("wrap_retired", 32'(retired_cnt_o), 32'd1);
        tick();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
